// File: rtl/key_bank.sv
// Multi-channel key front end: synchronises active-low keys, debounces, and emits press/release/long/repeat pulses.
// Latency: press/release pulses DEB_CYCLES+2 edges after the first sample; no backpressure, events are single-cycle pulses.
module key_bank #(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 1000000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic              FPGA_CLK,
    input  logic              RESET_BUT,
    input  logic [N_KEYS-1:0] KEY,
    input  logic [N_KEYS-1:0] REPEAT_EN,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              any_press
);

    localparam int MAX_DL = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
    localparam int MAX_C  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_HELD,
        S_LONG,
        S_DEB_REL
    } state_t;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        state_t        r_state;
        logic [CW-1:0] r_cnt;
        logic          r_was_long;
        logic          r_sync1;
        logic          r_sync2;
        logic          r_key_state;
        logic          r_press;
        logic          r_release;
        logic          r_long;
        logic          r_repeat;

        always_ff @(posedge FPGA_CLK) begin
            if (!RESET_BUT) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_was_long  <= 1'b0;
                r_sync1     <= 1'b0;
                r_sync2     <= 1'b0;
                r_key_state <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long      <= 1'b0;
                r_repeat    <= 1'b0;
            end else begin
                r_sync1   <= ~KEY[g];
                r_sync2   <= r_sync1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
                r_repeat  <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (r_sync2) begin
                            r_state <= S_DEB_PRESS;
                            r_cnt   <= '0;
                        end
                    end
                    S_DEB_PRESS: begin
                        if (!r_sync2) begin
                            r_state <= S_IDLE;
                        end else if (r_cnt == DEB_LAST) begin
                            r_state     <= S_HELD;
                            r_press     <= 1'b1;
                            r_key_state <= 1'b1;
                            r_cnt       <= '0;
                            r_was_long  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_HELD: begin
                        if (!r_sync2) begin
                            r_state <= S_DEB_REL;
                            r_cnt   <= '0;
                        end else if (r_cnt == LONG_LAST) begin
                            r_state    <= S_LONG;
                            r_long     <= 1'b1;
                            r_cnt      <= '0;
                            r_was_long <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_LONG: begin
                        // Disabled repeat parks the timer so re-enabling starts a full period.
                        if (!r_sync2) begin
                            r_state <= S_DEB_REL;
                            r_cnt   <= '0;
                        end else if (!REPEAT_EN[g]) begin
                            r_cnt <= '0;
                        end else if (r_cnt == RPT_LAST) begin
                            r_repeat <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    S_DEB_REL: begin
                        if (r_sync2) begin
                            r_state <= r_was_long ? S_LONG : S_HELD;
                            r_cnt   <= '0;
                        end else if (r_cnt == DEB_LAST) begin
                            r_state     <= S_IDLE;
                            r_release   <= 1'b1;
                            r_key_state <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign key_state[g]     = r_key_state;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign long_pulse[g]    = r_long;
        assign repeat_pulse[g]  = r_repeat;
    end

    assign any_press = |press_pulse;

endmodule

// File: tb/tb_key_bank.sv
// Bench for key_bank: timestamp-based reference model checked every cycle, plus directed literal timing checks.
module tb_key_bank;
    localparam int N   = 2;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int RPT = 8;

    logic         clk = 1'b0;
    logic         rst_b;
    logic [N-1:0] key;
    logic [N-1:0] rep_en;
    logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic         any_press;

    key_bank #(.N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(RPT)) dut (
        .FPGA_CLK(clk), .RESET_BUT(rst_b), .KEY(key), .REPEAT_EN(rep_en),
        .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .any_press(any_press)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
        end
    endtask

    // Reference model: sync delay line, run lengths of sync samples, timestamps of timer starts.
    bit           m_s1[N], m_s2[N], m_lvl[N], m_wl[N];
    int           m_run0[N], m_run1[N], m_start[N];
    logic [N-1:0] e_ks, e_press, e_rel, e_long, e_rpt;

    always @(posedge clk) begin
        cyc++;
        e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        if (!rst_b) begin
            chk_en = 1'b1;
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_wl[i] = 0;
                m_run0[i] = 0; m_run1[i] = 0; m_start[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit s;
                s = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = !key[i];
                if (s) begin m_run1[i]++; m_run0[i] = 0; end
                else   begin m_run0[i]++; m_run1[i] = 0; end
                if (!m_lvl[i]) begin
                    if (s && m_run1[i] == DEB + 1) begin
                        e_press[i] = 1; m_lvl[i] = 1; m_wl[i] = 0; m_start[i] = cyc;
                    end
                end else if (!s) begin
                    if (m_run0[i] == DEB + 1) begin e_rel[i] = 1; m_lvl[i] = 0; end
                end else if (m_run1[i] == 1) begin
                    m_start[i] = cyc;
                end else if (!m_wl[i]) begin
                    if (cyc - m_start[i] == LNG) begin e_long[i] = 1; m_wl[i] = 1; m_start[i] = cyc; end
                end else if (!rep_en[i]) begin
                    m_start[i] = cyc;
                end else if (cyc - m_start[i] == RPT) begin
                    e_rpt[i] = 1; m_start[i] = cyc;
                end
            end
        end
        for (int i = 0; i < N; i++) e_ks[i] = m_lvl[i];
    end

    // Per-cycle compare plus event statistics used by the directed checks.
    int n_press[N], n_rel[N], n_long[N], n_rpt[N], t_press[N], t_rel[N], t_long[N], t_rpt1[N];
    int n_any;

    task automatic clr_stats();
        for (int i = 0; i < N; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rpt[i] = 0;
            t_press[i] = -1000; t_rel[i] = -1000; t_long[i] = -1000; t_rpt1[i] = -1000;
        end
        n_any = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("key_state", int'(key_state), int'(e_ks));
            chk("press_pulse", int'(press_pulse), int'(e_press));
            chk("release_pulse", int'(release_pulse), int'(e_rel));
            chk("long_pulse", int'(long_pulse), int'(e_long));
            chk("repeat_pulse", int'(repeat_pulse), int'(e_rpt));
            chk("any_press", int'(any_press), int'(|e_press));
        end
        for (int i = 0; i < N; i++) begin
            if (press_pulse[i])   begin n_press[i]++; t_press[i] = cyc; end
            if (release_pulse[i]) begin n_rel[i]++;   t_rel[i]   = cyc; end
            if (long_pulse[i])    begin n_long[i]++;  t_long[i]  = cyc; end
            if (repeat_pulse[i])  begin if (n_rpt[i] == 0) t_rpt1[i] = cyc; n_rpt[i]++; end
        end
        if (any_press) n_any++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int t0, t1, h0, r;

    initial begin
        rst_b  = 1'b0;
        key    = '1;
        rep_en = '0;
        clr_stats();
        wait_cyc(3);
        chk("reset_key_state", int'(key_state), 0);
        chk("reset_pulses", int'(press_pulse | release_pulse | long_pulse | repeat_pulse), 0);
        rst_b = 1'b1;
        wait_cyc(5);

        // Short press and release on key 0.
        clr_stats();
        t0 = cyc + 1; key[0] = 1'b0; wait_cyc(12);
        t1 = cyc + 1; key[0] = 1'b1; wait_cyc(20);
        chk("t1_press_lat", t_press[0] - t0, 6);
        chk("t1_release_lat", t_rel[0] - t1, 6);
        chk("t1_no_long", n_long[0], 0);
        chk("t1_one_press", n_press[0], 1);

        // Glitch shorter than the debounce window.
        clr_stats();
        key[0] = 1'b0; wait_cyc(3);
        key[0] = 1'b1; wait_cyc(15);
        chk("t2_glitch_press", n_press[0], 0);

        // Long hold on key 1 with auto-repeat.
        clr_stats();
        rep_en = 2'b10;
        t0 = cyc + 1; key[1] = 1'b0; wait_cyc(70);
        key[1] = 1'b1; wait_cyc(15);
        chk("t3_long_lat", t_long[1] - t0, 26);
        chk("t3_first_rpt", t_rpt1[1] - t0, 34);
        chk("t3_rpt_count", n_rpt[1], 5);
        chk("t3_release", n_rel[1], 1);

        // Same hold with repeat disabled.
        clr_stats();
        rep_en = 2'b00;
        key[1] = 1'b0; wait_cyc(70);
        key[1] = 1'b1; wait_cyc(15);
        chk("t3b_long_count", n_long[1], 1);
        chk("t3b_rpt_count", n_rpt[1], 0);

        // Short bounce high after long press: timer restarts, no release.
        clr_stats();
        rep_en = 2'b10;
        key[1] = 1'b0; wait_cyc(30);
        h0 = cyc + 1; key[1] = 1'b1; wait_cyc(2);
        key[1] = 1'b0; wait_cyc(20);
        chk("t4_no_release", n_rel[1], 0);
        chk("t4_still_held", int'(key_state[1]), 1);
        chk("t4_rpt_after_bounce", t_rpt1[1] - h0, 12);
        key[1] = 1'b1; rep_en = 2'b00; wait_cyc(15);

        // Simultaneous presses.
        clr_stats();
        key = 2'b00; wait_cyc(12);
        key = 2'b11; wait_cyc(15);
        chk("t5_any_press_cycles", n_any, 1);
        chk("t5_same_cycle", t_press[0] - t_press[1], 0);
        chk("t5_both_pressed", n_press[0] + n_press[1], 2);

        // Reset while key 0 is in long-hold; key stays down through release.
        clr_stats();
        key[0] = 1'b0; wait_cyc(30);
        chk("t6_long_before_reset", n_long[0], 1);
        rst_b = 1'b0; r = cyc + 1; wait_cyc(1);
        chk("t6_reset_state", int'(key_state), 0);
        chk("t6_reset_long", int'(long_pulse), 0);
        rst_b = 1'b1; wait_cyc(15);
        chk("t6_no_release", n_rel[0], 0);
        chk("t6_repress_lat", t_press[0] - (r + 1), 6);
        chk("t6_press_count", n_press[0], 2);
        key[0] = 1'b1; wait_cyc(15);
        chk("t6_final_release", n_rel[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
